// File: rtl/verisc_pkg.sv
// verisc_pkg: shared VeriRISC bus widths, responder states and op codes
package verisc_pkg;
  localparam int AWIDTH = 5;
  localparam int DWIDTH = 8;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef enum logic {OP_RD, OP_WR} op_t;
endpackage

// File: rtl/mem_array.sv
// mem_array: DEPTH x DWIDTH storage, one synchronous write port, combinational read
module mem_array #(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 1 << AWIDTH
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic [AWIDTH-1:0] raddr,
  output logic [DWIDTH-1:0] rdata
);
  logic [DWIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/mem_responder.sv
// mem_responder: wait-state memory responder for the VeriRISC bus with host preload port
module mem_responder
  import verisc_pkg::*;
#(
  parameter int AWIDTH      = verisc_pkg::AWIDTH,
  parameter int DWIDTH      = verisc_pkg::DWIDTH,
  parameter int DEPTH       = 1 << AWIDTH,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd,
  input  logic              wr,
  input  logic [AWIDTH-1:0] addr,
  input  logic [DWIDTH-1:0] wdata,
  output logic [DWIDTH-1:0] rdata,
  output logic              ack,
  output logic              busy,
  output logic              err,
  input  logic              ld_en,
  input  logic [AWIDTH-1:0] ld_addr,
  input  logic [DWIDTH-1:0] ld_data,
  output logic              ld_ready
);
  state_t            state;
  op_t               op;
  logic [2:0]        cnt;
  logic              req_seen, start, commit, we;
  logic [AWIDTH-1:0] a_q, waddr;
  logic [DWIDTH-1:0] d_q, wd, mem_rdata;

  assign start    = state == IDLE && (rd || wr) && !req_seen;
  assign ld_ready = state == IDLE && !start;
  assign busy     = state != IDLE;
  // a reset arriving on the WAIT->RESP edge must suppress the commit
  assign commit   = state == WAIT && cnt == 3'd0 && op == OP_WR && !rst;
  assign we       = commit || (ld_en && ld_ready);
  assign waddr    = commit ? a_q : ld_addr;
  assign wd       = commit ? d_q : ld_data;

  mem_array #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH), .DEPTH(DEPTH)) u_mem (
    .clk(clk), .we(we), .waddr(waddr), .wdata(wd), .raddr(a_q), .rdata(mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 3'd0;
      req_seen <= 1'b0;
      ack      <= 1'b0;
      rdata    <= '0;
      err      <= 1'b0;
    end else begin
      ack <= 1'b0;
      if (!rd && !wr) req_seen <= 1'b0;
      else if (start) req_seen <= 1'b1;
      case (state)
        IDLE: if (start) begin
          state <= WAIT;
          cnt   <= 3'(WAIT_STATES);
          a_q   <= addr;
          d_q   <= wdata;
          op    <= rd ? OP_RD : OP_WR;
          if (rd && wr) err <= 1'b1;
        end
        WAIT: if (cnt != 3'd0) cnt <= cnt - 3'd1;
        else begin
          state <= RESP;
          ack   <= 1'b1;
          if (op == OP_RD) rdata <= mem_rdata;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized transactions checked against a word-array reference model
module tb_mem_responder;
  localparam int WS = 1;
  logic       clk = 0, rst = 1, rd = 0, wr = 0, ld_en = 0;
  logic [4:0] addr = 0, ld_addr = 0;
  logic [7:0] wdata = 0, ld_data = 0;
  logic [7:0] rdata;
  logic       ack, busy, err, ld_ready;
  logic [7:0] m [32];
  logic [7:0] rdata_m = 0;
  logic       err_m = 0;
  int         n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  mem_responder #(.WAIT_STATES(WS)) dut (
    .clk(clk), .rst(rst), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ack(ack), .busy(busy), .err(err),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic preload(input logic [4:0] a, input logic [7:0] d);
    ld_en = 1; ld_addr = a; ld_data = d;
    #1 chk("ld_ready_idle", ld_ready, 1);
    @(negedge clk);
    ld_en = 0;
    m[a] = d;
  endtask

  // ld_at: 0 none, 1 preload attempt on the capture cycle, 2 on the first WAIT cycle
  task automatic txn(input logic r, input logic w, input logic [4:0] a, input logic [7:0] d,
                     input int hold, input int ld_at);
    int n;
    rd = r; wr = w; addr = a; wdata = d;
    if (ld_at == 1) begin ld_en = 1; ld_addr = a ^ 5'd1; ld_data = ~m[a ^ 5'd1]; end
    #1 chk("ld_ready_start", ld_ready, 0);
    n = 0;
    do begin
      @(negedge clk);
      ld_en = 0;
      n++;
      if (n == 1) begin
        if (ld_at == 2) begin
          ld_en = 1; ld_addr = a ^ 5'd2; ld_data = ~m[a ^ 5'd2];
          #1 chk("ld_ready_wait", ld_ready, 0);
        end
        if (hold == 0) begin rd = 0; wr = 0; addr = 5'($urandom); wdata = 8'($urandom); end
      end
      if (!ack) chk("busy_wait", busy, 1);
    end while (!ack && n < 20);
    chk("latency", n, WS + 2);
    chk("busy_resp", busy, 1);
    if (r) rdata_m = m[a];
    else m[a] = d;
    if (r && w) err_m = 1;
    chk("rdata", rdata, rdata_m);
    chk("err", err, err_m);
    @(negedge clk);
    chk("ack_pulse", ack, 0);
    chk("busy_idle", busy, 0);
    chk("rdata_held", rdata, rdata_m);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("no_reack", ack, 0);
    end
    rd = 0; wr = 0;
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_rdata", rdata, 0);
    rst = 0;
    for (int i = 0; i < 32; i++) preload(5'(i), 8'($urandom));
    preload(5'd3, 8'hA5);
    txn(1, 0, 5'd3, 8'h00, 0, 0);
    chk("plan1_a5", rdata, 8'hA5);
    txn(0, 1, 5'd7, 8'h3C, 0, 0);
    txn(1, 0, 5'd7, 8'h00, 0, 0);
    chk("plan2_3c", rdata, 8'h3C);
    txn(1, 0, 5'd3, 8'h00, 6, 0);
    txn(1, 0, 5'd3, 8'h00, 0, 0);
    txn(1, 1, 5'd5, 8'h77, 0, 0);
    txn(1, 0, 5'd5, 8'h00, 0, 0);
    chk("err_sticky", err, 1);
    txn(1, 0, 5'd12, 8'h00, 0, 2);
    txn(1, 0, 5'd14, 8'h00, 0, 0);
    preload(5'd14, 8'h5A);
    txn(1, 0, 5'd14, 8'h00, 0, 0);
    for (int i = 0; i < 40; i++) begin
      int k;
      logic r;
      k = $urandom_range(0, 9);
      r = 1'($urandom);
      if (k == 0) preload(5'($urandom), 8'($urandom));
      else txn(r || k == 1, !r || k == 1, 5'($urandom), 8'($urandom),
               ($urandom_range(0, 3) == 0) ? 3 : 0, $urandom_range(0, 5) % 3);
    end
    wr = 1; addr = 5'd9; wdata = ~m[9];
    @(negedge clk);
    wr = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    err_m = 0; rdata_m = 0;
    chk("mid_rst_ack", ack, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_rdata", rdata, 0);
    chk("mid_rst_ld_ready", ld_ready, 1);
    txn(1, 0, 5'd9, 8'h00, 0, 0);
    for (int i = 0; i < 32; i++) txn(1, 0, 5'(i), 8'h00, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
